// File: rtl/uart_frame_sched_pkg.sv
// Shared types and constants for the UART frame scheduler.
// Used by uart_frame_sched; the CSUM encoding is reserved even when the
// checksum build option (UART_FRAME_SCHED_CHECKSUM_EN) is off.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
    localparam int         NUM_DATA_BYTES = 4;
    localparam int         IDX_W          = 2;

    // Frame checksum: XOR of the four data bytes, sync byte excluded.
    function automatic logic [7:0] frame_csum(input logic [7:0] b0,
                                              input logic [7:0] b1,
                                              input logic [7:0] b2,
                                              input logic [7:0] b3);
        return b0 ^ b1 ^ b2 ^ b3;
    endfunction

endpackage

// File: rtl/uart_frame_sched_if.sv
// Byte stream between the frame scheduler (master) and uart_tx (slave).
interface uart_frame_sched_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_frame_sched_tick_gen.sv
// Enable-gated period counter producing a one-cycle launch tick.
// The counter sits at zero while disabled, so the first tick lands
// exactly FRAME_PERIOD cycles after en rises.
module frame_tick_gen #(
    parameter int unsigned FRAME_PERIOD = 50000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next count: cleared while disabled or on wrap, otherwise increments.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_sched.sv
// Periodic frame scheduler: snapshots four sensor registers on each launch
// tick and streams SYNC, reg0..reg3 (and a checksum when
// UART_FRAME_SCHED_CHECKSUM_EN is defined) over a valid/ready byte stream.
//
// state | meaning
// IDLE  | waiting for a launch tick
// SYNC  | presenting SYNC_BYTE
// DATA  | presenting snapshot[idx], idx = 0..3
// CSUM  | presenting XOR checksum (checksum build only)
module uart_frame_sched
    import uart_frame_pkg::*;
#(
    parameter int unsigned FRAME_PERIOD = 50000,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [7:0]          reg0,
    input  logic [7:0]          reg1,
    input  logic [7:0]          reg2,
    input  logic [7:0]          reg3,
    uart_frame_sched_if.master  tx,
    output logic                busy,
    output logic                overrun,
    input  logic                overrun_clr,
    output logic [15:0]         frame_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DATA_BYTES - 1);

    logic             tick;
    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_inc;
    logic [7:0]       snap_q [NUM_DATA_BYTES];
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic             overrun_q;
    logic [15:0]      frame_cnt_q;
    logic             hs;

    frame_tick_gen #(
        .FRAME_PERIOD (FRAME_PERIOD),
        .CNT_W        (CNT_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    assign hs      = tx_valid_q & tx.tx_ready;
    assign idx_inc = idx_q + IDX_W'(1);

    // Frame sequencer with registered byte stream outputs and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
            for (int i = 0; i < NUM_DATA_BYTES; i++) begin
                snap_q[i] <= 8'h00;
            end
        end else begin
            // A tick while a frame is in flight is dropped; set beats clear.
            if (tick && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        snap_q[0]  <= reg0;
                        snap_q[1]  <= reg1;
                        snap_q[2]  <= reg2;
                        snap_q[3]  <= reg3;
                        idx_q      <= '0;
                        tx_data_q  <= SYNC_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (hs) begin
                        tx_data_q <= snap_q[0];
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (hs) begin
                        if (idx_q == LAST_IDX) begin
`ifdef UART_FRAME_SCHED_CHECKSUM_EN
                            tx_data_q <= frame_csum(snap_q[0], snap_q[1],
                                                    snap_q[2], snap_q[3]);
                            state_q   <= ST_CSUM;
`else
                            tx_valid_q  <= 1'b0;
                            state_q     <= ST_IDLE;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
                        end else begin
                            idx_q     <= idx_inc;
                            tx_data_q <= snap_q[idx_inc];
                        end
                    end
                end
`ifdef UART_FRAME_SCHED_CHECKSUM_EN
                ST_CSUM: begin
                    if (hs) begin
                        tx_valid_q  <= 1'b0;
                        state_q     <= ST_IDLE;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
`endif
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign overrun     = overrun_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Self-checking bench for uart_frame_sched (FRAME_PERIOD=16).
// Works in both the default and the UART_FRAME_SCHED_CHECKSUM_EN build.
module tb_uart_frame_sched;

    localparam int P = 16;
`ifdef UART_FRAME_SCHED_CHECKSUM_EN
    localparam int FL = 6;
`else
    localparam int FL = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        overrun_clr = 1'b0;
    logic [7:0]  reg0 = 8'h00;
    logic [7:0]  reg1 = 8'h00;
    logic [7:0]  reg2 = 8'h00;
    logic [7:0]  reg3 = 8'h00;
    logic        busy;
    logic        overrun;
    logic [15:0] frame_cnt;

    uart_frame_sched_if tx ();

    uart_frame_sched #(
        .FRAME_PERIOD (P),
        .SYNC_BYTE    (8'hA5),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .reg0        (reg0),
        .reg1        (reg1),
        .reg2        (reg2),
        .reg3        (reg3),
        .tx          (tx),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .frame_cnt   (frame_cnt)
    );

    int         n_tests = 0;
    int         n_fail = 0;
    int         exp_frames = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    // Scoreboard: every accepted byte must match the head of the queue.
    always @(negedge clk) begin
        logic [7:0] e;
        #2;
        if (rst_n && tx.tx_valid && tx.tx_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_byte got %h want none", tx.tx_data);
            end else begin
                e = exp_q.pop_front();
                if (tx.tx_data !== e) begin
                    n_fail++;
                    $display("FAIL sb_byte got %h want %h", tx.tx_data, e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        exp_q.push_back(8'hA5);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
`ifdef UART_FRAME_SCHED_CHECKSUM_EN
        exp_q.push_back(a ^ b ^ c ^ d);
`endif
        exp_frames++;
    endtask

    // Loads regs, raises en and returns at the negedge where SYNC is shown.
    task automatic launch(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d,
                          input bit keep_en);
        bit seen;
        seen = 1'b0;
        reg0 = a; reg1 = b; reg2 = c; reg3 = d;
        push_frame(a, b, c, d);
        en = 1'b1;
        for (int k = 0; k < P + 4; k++) begin
            @(negedge clk);
            if (tx.tx_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!keep_en) en = 1'b0;
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL launch_timeout got no_valid want valid");
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain_timeout got pending=%0d want 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({tx.tx_valid, tx.tx_data, busy, overrun, frame_cnt} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b d=%h b=%b o=%b f=%0d want zeros",
                     tx.tx_valid, tx.tx_data, busy, overrun, frame_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] seq [6];
        bit         exp_v;
        int         bad_idle;
        seq[0] = 8'hA5; seq[1] = 8'h11; seq[2] = 8'h22;
        seq[3] = 8'h33; seq[4] = 8'h44; seq[5] = 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44;
        tx.tx_ready = 1'b1;
        reg0 = 8'h11; reg1 = 8'h22; reg2 = 8'h33; reg3 = 8'h44;
        push_frame(8'h11, 8'h22, 8'h33, 8'h44);
        en = 1'b1;
        for (int k = 1; k <= P + FL; k++) begin
            @(negedge clk);
            exp_v = (k >= P) && (k < P + FL);
            n_tests++;
            if (tx.tx_valid !== exp_v) begin
                n_fail++;
                $display("FAIL basic_valid_k%0d got %b want %b", k, tx.tx_valid, exp_v);
            end
            if (exp_v) begin
                n_tests++;
                if (tx.tx_data !== seq[k-P]) begin
                    n_fail++;
                    $display("FAIL basic_data_k%0d got %h want %h", k, tx.tx_data, seq[k-P]);
                end
            end
        end
        n_tests++;
        if (frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL basic_frame_cnt got %0d want %0d", frame_cnt, exp_frames);
        end
        en = 1'b0;
        bad_idle = 0;
        repeat (2 * P) begin
            @(negedge clk);
            if (tx.tx_valid !== 1'b0) bad_idle++;
        end
        n_tests++;
        if (bad_idle != 0) begin
            n_fail++;
            $display("FAIL basic_en_low_quiet got %0d valid cycles want 0", bad_idle);
        end
    endtask

    task automatic test_backpressure();
        bit found;
        found = 1'b0;
        tx.tx_ready = 1'b1;
        launch(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx.tx_valid && tx.tx_data == 8'h22) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL bp_find_reg1 got absent want 22");
        end
        tx.tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (tx.tx_valid !== 1'b1 || tx.tx_data !== 8'h22) begin
                n_fail++;
                $display("FAIL bp_hold_%0d got v=%b d=%h want v=1 d=22", i, tx.tx_valid, tx.tx_data);
            end
            if (i < 5) @(negedge clk);
        end
        tx.tx_ready = 1'b1;
        wait_idle("bp");
        n_tests++;
        if (frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL bp_frame_cnt got %0d want %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_snapshot();
        tx.tx_ready = 1'b1;
        launch(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        reg2 = 8'h99;
        wait_idle("snap1");
        launch(8'h11, 8'h22, 8'h99, 8'h44, 1'b0);
        wait_idle("snap2");
        n_tests++;
        if (frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL snap_frame_cnt got %0d want %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_overrun();
        int bad_idle;
        tx.tx_ready = 1'b0;
        launch(8'h5A, 8'hC3, 8'h0F, 8'hF0, 1'b1);
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_initial got %b want 0", overrun);
        end
        repeat (20) @(negedge clk);
        en = 1'b0;
        n_tests++;
        if (overrun !== 1'b1 || tx.tx_valid !== 1'b1 || tx.tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL ovr_set got o=%b v=%b d=%h want o=1 v=1 d=a5",
                     overrun, tx.tx_valid, tx.tx_data);
        end
        tx.tx_ready = 1'b1;
        wait_idle("ovr");
        bad_idle = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx.tx_valid !== 1'b0) bad_idle++;
        end
        n_tests++;
        if (bad_idle != 0 || frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL ovr_single_frame got extra=%0d cnt=%0d want 0 cnt=%0d",
                     bad_idle, frame_cnt, exp_frames);
        end
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky got %b want 1", overrun);
        end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear got %b want 0", overrun);
        end
        // Clear asserted in the same cycle as a tick during busy.
        tx.tx_ready = 1'b0;
        launch(8'h01, 8'h10, 8'h20, 8'h40, 1'b1);
        repeat (P - 1) @(negedge clk);
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_pre_tick got %b want 0", overrun);
        end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        en = 1'b0;
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set_wins got %b want 1", overrun);
        end
        tx.tx_ready = 1'b1;
        wait_idle("ovr2");
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
    endtask

    task automatic test_checksum();
        bit         found;
        logic [7:0] last_exp;
`ifdef UART_FRAME_SCHED_CHECKSUM_EN
        last_exp = 8'h0F;
`else
        last_exp = 8'h08;
`endif
        found = 1'b0;
        tx.tx_ready = 1'b1;
        launch(8'h01, 8'h02, 8'h04, 8'h08, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (tx.tx_valid && exp_q.size() == 1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (!found || tx.tx_data !== last_exp) begin
            n_fail++;
            $display("FAIL csum_last_byte got %h want %h", tx.tx_data, last_exp);
        end
        n_tests++;
        if (frame_cnt !== 16'(exp_frames - 1)) begin
            n_fail++;
            $display("FAIL csum_cnt_before got %0d want %0d", frame_cnt, exp_frames - 1);
        end
        @(negedge clk);
        n_tests++;
        if (frame_cnt !== 16'(exp_frames) || tx.tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL csum_cnt_after got cnt=%0d v=%b want cnt=%0d v=0",
                     frame_cnt, tx.tx_valid, exp_frames);
        end
        wait_idle("csum");
    endtask

    task automatic test_reset_midframe();
        bit found;
        found = 1'b0;
        tx.tx_ready = 1'b1;
        launch(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx.tx_valid && tx.tx_data == 8'h22) begin
                found = 1'b1;
                break;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (!found || {tx.tx_valid, tx.tx_data, busy, overrun, frame_cnt} !== 27'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async got found=%b v=%b d=%h b=%b o=%b f=%0d want zeros",
                     found, tx.tx_valid, tx.tx_data, busy, overrun, frame_cnt);
        end
        exp_q.delete();
        exp_frames = 0;
        @(negedge clk);
        rst_n = 1'b1;
        reg0 = 8'h55; reg1 = 8'h66; reg2 = 8'h77; reg3 = 8'h88;
        push_frame(8'h55, 8'h66, 8'h77, 8'h88);
        en = 1'b1;
        for (int k = 1; k <= P; k++) begin
            @(negedge clk);
            n_tests++;
            if (tx.tx_valid !== (k == P)) begin
                n_fail++;
                $display("FAIL rst_relaunch_valid_k%0d got %b want %b", k, tx.tx_valid, (k == P));
            end
        end
        en = 1'b0;
        n_tests++;
        if (tx.tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL rst_relaunch_sync got %h want a5", tx.tx_data);
        end
        wait_idle("rst");
        n_tests++;
        if (frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL rst_frame_cnt got %0d want %0d", frame_cnt, exp_frames);
        end
    endtask

    initial begin
        tx.tx_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_overrun();
        test_checksum();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
